// File: rtl/sk_adder_if.sv
// Operand/result handshake bundle for the pipelined Sklansky adder.
interface sk_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/sk_adder_pipe.sv
// Add/subtract built on a Sklansky prefix network, cut into STAGES register
// stages with a single global stall (adv) driven by the output handshake.
module sk_adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input logic      clk,
    input logic      rst_n,
    sk_adder_if.slave bus
);
    localparam int LV    = $clog2(WIDTH);
    localparam int NSTEP = LV + 2;   // gp, LV prefix levels, final xor

    typedef struct packed {
        logic [WIDTH-1:0] hp;   // half-sum a ^ b_eff, kept for the final xor
        logic [WIDTH-1:0] gg;   // group generate
        logic [WIDTH-1:0] pp;   // group propagate
        logic             c0;
        logic             am;
        logic             bm;
    } step_t;

    // Stage index of each step; a register sits wherever it increments.
    function automatic int stg(input int s);
        return (s * STAGES) / NSTEP;
    endfunction

    logic adv;

    // Reset forces the pipe to advance so in_ready stays high throughout it.
    assign adv          = !rst_n || !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar s = 0; s <= LV; s++) begin : g_step
        step_t xo;
        logic  vo;

        if (s == 0) begin : g_gp
            logic [WIDTH-1:0] beff;
            always_comb begin
                beff  = bus.sub ? ~bus.b : bus.b;
                xo.hp = bus.a ^ beff;
                xo.pp = bus.a ^ beff;
                xo.gg = bus.a & beff;
                xo.c0 = bus.sub | bus.cin;
                xo.am = bus.a[WIDTH-1];
                xo.bm = beff[WIDTH-1];
            end
            assign vo = bus.in_valid;
        end else begin : g_lvl
            localparam int K = s - 1;
            step_t di;
            logic  vi;

            if (stg(s) != stg(s - 1)) begin : g_reg
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        di <= '0;
                        vi <= 1'b0;
                    end else if (adv) begin
                        di <= g_step[s-1].xo;
                        vi <= g_step[s-1].vo;
                    end
                end
            end else begin : g_wire
                assign di = g_step[s-1].xo;
                assign vi = g_step[s-1].vo;
            end

            // Upper half of each 2^(K+1) block takes the top bit of the lower half.
            always_comb begin
                xo = di;
                for (int i = 0; i < WIDTH; i++) begin
                    if (((i >> K) & 1) == 1) begin
                        xo.gg[i] = di.gg[i] | (di.pp[i] & di.gg[((i >> K) << K) - 1]);
                        xo.pp[i] = di.pp[i] & di.pp[((i >> K) << K) - 1];
                    end
                end
            end
            assign vo = vi;
        end
    end

    step_t df;
    logic  vf;

    if (stg(LV + 1) != stg(LV)) begin : g_freg
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                df <= '0;
                vf <= 1'b0;
            end else if (adv) begin
                df <= g_step[LV].xo;
                vf <= g_step[LV].vo;
            end
        end
    end else begin : g_fwire
        assign df = g_step[LV].xo;
        assign vf = g_step[LV].vo;
    end

    // Carry-in is applied after the prefix tree: c[i+1] = G[i:0] | P[i:0] & c0.
    logic [WIDTH-1:0] cy;
    logic [WIDTH-1:0] rs;

    assign cy = df.gg | (df.pp & {WIDTH{df.c0}});
    assign rs = df.hp ^ {cy[WIDTH-2:0], df.c0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.cout      <= 1'b0;
            bus.ovf       <= 1'b0;
        end else if (adv) begin
            bus.out_valid <= vf;
            if (vf) begin
                bus.sum  <= rs;
                bus.cout <= cy[WIDTH-1];
                bus.ovf  <= (df.am == df.bm) && (rs[WIDTH-1] != df.am);
            end
        end
    end
endmodule

// File: tb/tb_sk_adder_pipe.sv
// Bench for sk_adder_pipe (WIDTH=16, STAGES=2): directed table, stall and reset
// sequences, and random traffic, all checked against a behavioural scoreboard.
module tb_sk_adder_pipe;
    localparam int W = 16;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sk_adder_if #(.WIDTH(W)) bus ();

    sk_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;
    logic [17:0] sb[$];

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] s;
        logic        co, ov;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] be;
        logic [16:0] r;
        logic        ov;
        be = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, be} + {16'd0, (sub ? 1'b1 : cin)};
        ov = (a[15] == be[15]) && (r[15] != a[15]);
        return {r[16], r[15:0], ov};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: push on accepted input, compare head on every valid output.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %h expected no result",
                             {bus.cout, bus.sum, bus.ovf});
                end else begin
                    chk(bus.out_ready ? "sb_pop" : "sb_hold", {14'd0, bus.cout, bus.sum, bus.ovf}, {14'd0, sb[0]});
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
                acc_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after acceptance with in_valid low.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        int  n;
        bit  done;
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
        n = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) done = 1;
            else if (++n > 200) begin
                chk("send_timeout", 32'd0, 32'd1);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        chk(nm, sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int cyc;
        logic [15:0] c4[4];

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h1234, 16'h0001, 1'b1, 1'b0, 16'h1236, 1'b0, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[4] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[5] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        c4[0] = 16'h0000; c4[1] = 16'hFFFF; c4[2] = 16'h8000; c4[3] = 16'h7FFF;

        // Reset with garbage input and a stalled output.
        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.cin = 1'b1; bus.sub = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout_ovf", {bus.cout, bus.ovf}, 0);
        chk("rst_in_ready_after", bus.in_ready, 1);
        tick();
        bus.out_ready = 1'b1;

        // Directed table: exact latency and values.
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
            @(negedge clk);
            chk($sformatf("lat_early_%0d", i), bus.out_valid, 0);
            tick();
            @(negedge clk);
            chk($sformatf("lat_valid_%0d", i), bus.out_valid, 1);
            chk($sformatf("tbl_%0d", i), {bus.cout, bus.sum, bus.ovf}, {tbl[i].co, tbl[i].s, tbl[i].ov});
            tick();
        end

        // Back-to-back with a stalled sink.
        bus.out_ready = 1'b0;
        send(16'h0101, 16'h0202, 1'b0, 1'b0);
        send(16'h1000, 16'h0001, 1'b0, 1'b1);
        fork
            begin
                send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
                send(16'h4000, 16'h4000, 1'b0, 1'b0);
            end
            begin
                @(negedge clk);
                chk("stall_in_ready", bus.in_ready, 0);
                chk("stall_out_valid", bus.out_valid, 1);
                chk("stall_resident", sb.size(), 2);
                tick(); tick();
                @(negedge clk);
                chk("stall_sum_held", bus.sum, 16'h0303);
                tick();
                bus.out_ready = 1'b1;
                cnt = 0;
                repeat (4) begin
                    @(negedge clk);
                    if (bus.out_valid) cnt++;
                end
                chk("release_no_gaps", cnt, 4);
            end
        join
        tick();
        drain("b2b_drain");

        // Reset with two transfers in flight.
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b0, 1'b0);
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_in_ready", bus.in_ready, 1);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_sum", bus.sum, 0);
        chk("midrst_in_ready_after", bus.in_ready, 1);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        chk("midrst_no_stale", cnt, 0);
        tick();

        // Random traffic with random valid/ready.
        cnt = acc_cnt;
        cyc = 0;
        while (acc_cnt < cnt + 3000 && cyc < 20000) begin
            bus.a   = ($urandom_range(0, 3) == 0) ? c4[$urandom_range(0, 3)] : 16'($urandom);
            bus.b   = ($urandom_range(0, 3) == 0) ? c4[$urandom_range(0, 3)] : 16'($urandom);
            bus.cin = 1'($urandom);
            bus.sub = 1'($urandom);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("rand_accepted", (acc_cnt >= cnt + 3000), 1);
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
